psum_drain: RTL and testbench

//  Drain end of a PE column array: captures the skewed partial sums leaving the bottom row of NCOL

---
 rtl/pe_array_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/psum_drain.sv | 169 ++++++++++++++++
 tb/tb_psum_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared constants, FSM encoding and requantizer for the PE-array drain path.
package pe_array_pkg;

    localparam int NCOL   = 4;
    localparam int BW     = 16;
    localparam int ACC_BW = 24;
    localparam int OUT_BW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic signed [ACC_BW:0] SAT_HI = (ACC_BW+1)'(2**(OUT_BW-1) - 1);
    localparam logic signed [ACC_BW:0] SAT_LO = (ACC_BW+1)'(-(2**(OUT_BW-1)));

    // One extra bit of headroom so the rounding add cannot wrap.
    function automatic logic [OUT_BW-1:0] requant(input logic signed [ACC_BW-1:0] acc,
                                                  input int shift, input bit relu);
        logic signed [ACC_BW:0] v;
        v = {acc[ACC_BW-1], acc};
        if (shift > 0)
            v = v + ((ACC_BW+1)'(1) << (shift - 1));
        v = v >>> shift;
        if (relu && v[ACC_BW])
            v = '0;
        if (v > SAT_HI)
            return SAT_HI[OUT_BW-1:0];
        else if (v < SAT_LO)
            return SAT_LO[OUT_BW-1:0];
        return v[OUT_BW-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; read data reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         iCLK,
    input  logic                         iRSTn,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO may still accept.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/psum_drain.sv
// Deskews PE-column psums into rows, accumulates rows across K passes, requantizes
// the final pass and streams rows out through a FWFT FIFO.
//   state    | meaning
//   ST_IDLE  | waiting for iStart; aligned rows discarded
//   ST_RUN   | accumulating aligned rows, pushing requantized rows on the last pass
//   ST_DRAIN | all rows taken; waiting for the output FIFO to empty
//   ST_DONE  | one-cycle oDone, then back to idle
module psum_drain
    import pe_array_pkg::*;
#(
    parameter int MAX_ROWS = 16,
    parameter int OFIFO_D  = 4,
    parameter int SHIFT    = 0,
    parameter int RELU     = 0
) (
    input  logic                        iCLK,
    input  logic                        iRSTn,
    input  logic                        iStart,
    input  logic [$clog2(MAX_ROWS):0]   iNumRows,
    input  logic [7:0]                  iNumPass,
    input  logic                        iPsumVld,
    input  logic [NCOL*BW-1:0]          iPsum,
    output logic [NCOL*OUT_BW-1:0]      oData,
    output logic                        oValid,
    input  logic                        iReady,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oOvf
);
    localparam int RA = $clog2(MAX_ROWS);
    localparam int RW = RA + 1;

    state_t                      state, state_nxt;
    logic [RW-1:0]               num_rows_q, num_rows_in, row_cnt;
    logic [7:0]                  num_pass_q, num_pass_in, pass_cnt;
    logic [NCOL-1:0]             vld_sr;
    logic                        row_vld, take, last_row, last_pass;
    logic                        push, pop, drop, ovf_q;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(OFIFO_D+1)-1:0] fifo_count;
    logic [BW-1:0]               col_al [NCOL];
    logic signed [ACC_BW-1:0]    acc_mem [MAX_ROWS][NCOL];
    logic signed [ACC_BW-1:0]    sum [NCOL];
    logic [NCOL*OUT_BW-1:0]      push_data;
    logic [RA-1:0]               row_idx;

    // Column c gets NCOL-c register stages so every lane lands in the same cycle.
    for (genvar c = 0; c < NCOL; c++) begin : g_col
        localparam int D = NCOL - c;
        logic [BW-1:0] sr [D];
        always_ff @(posedge iCLK or negedge iRSTn) begin
            if (!iRSTn) begin
                for (int i = 0; i < D; i++) sr[i] <= '0;
            end else begin
                sr[0] <= iPsum[c*BW +: BW];
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
        end
        assign col_al[c] = sr[D-1];
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) vld_sr <= '0;
        else        vld_sr <= {vld_sr[NCOL-2:0], iPsumVld};
    end

    assign row_vld   = vld_sr[NCOL-1];
    assign row_idx   = row_cnt[RA-1:0];
    assign last_row  = (row_cnt == num_rows_q - RW'(1));
    assign last_pass = (pass_cnt == num_pass_q - 8'd1);

    always_comb begin
        num_rows_in = iNumRows;
        if (iNumRows == '0)                num_rows_in = RW'(1);
        else if (iNumRows > RW'(MAX_ROWS)) num_rows_in = RW'(MAX_ROWS);
        num_pass_in = (iNumPass == 8'd0) ? 8'd1 : iNumPass;
    end

    always_comb begin
        push_data = '0;
        for (int c = 0; c < NCOL; c++) begin
            sum[c] = {{(ACC_BW-BW){col_al[c][BW-1]}}, col_al[c]};
            if (pass_cnt != 8'd0)
                sum[c] = sum[c] + acc_mem[row_idx][c];
            push_data[c*OUT_BW +: OUT_BW] = requant(sum[c], SHIFT, RELU != 0);
        end
    end

    always_ff @(posedge iCLK) begin
        if (take)
            for (int c = 0; c < NCOL; c++) acc_mem[row_idx][c] <= sum[c];
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (iStart) state_nxt = ST_RUN;
            ST_RUN:   if (row_vld && last_row && last_pass) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_count == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        oBusy = 1'b0;
        oDone = 1'b0;
        take  = 1'b0;
        case (state)
            ST_RUN:   begin oBusy = 1'b1; take = row_vld; end
            ST_DRAIN: oBusy = 1'b1;
            ST_DONE:  oDone = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            num_rows_q <= '0;
            num_pass_q <= '0;
            row_cnt    <= '0;
            pass_cnt   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (state == ST_IDLE && iStart) begin
                num_rows_q <= num_rows_in;
                num_pass_q <= num_pass_in;
                row_cnt    <= '0;
                pass_cnt   <= '0;
                ovf_q      <= 1'b0;
            end else if (take) begin
                if (last_row) begin
                    row_cnt  <= '0;
                    pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    row_cnt  <= row_cnt + RW'(1);
                end
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign push   = take && last_pass;
    assign pop    = oValid && iReady;
    assign drop   = push && fifo_full && !pop;
    assign oValid = !fifo_empty;
    assign oOvf   = ovf_q;

    sync_fifo #(
        .WIDTH (NCOL*OUT_BW),
        .DEPTH (OFIFO_D)
    ) u_ofifo (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (oData),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: one instance with SHIFT=0/RELU=0, one with SHIFT=2/RELU=1.
module tb_psum_drain;

    logic        iCLK = 1'b0;
    logic        iRSTn, iStart, iPsumVld, iReady;
    logic [4:0]  iNumRows;
    logic [7:0]  iNumPass;
    logic [63:0] iPsum;
    logic [31:0] oData0, oData1;
    logic        oValid0, oValid1, oBusy0, oBusy1, oDone0, oDone1, oOvf0, oOvf1;

    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, first_vld = -1, mark = 0;
    logic [31:0] got0[$], got1[$];

    always #5 iCLK = ~iCLK;

    psum_drain #(.MAX_ROWS(16), .OFIFO_D(4), .SHIFT(0), .RELU(0)) u_d0 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iNumRows(iNumRows), .iNumPass(iNumPass),
        .iPsumVld(iPsumVld), .iPsum(iPsum), .oData(oData0), .oValid(oValid0), .iReady(iReady),
        .oBusy(oBusy0), .oDone(oDone0), .oOvf(oOvf0));

    psum_drain #(.MAX_ROWS(16), .OFIFO_D(4), .SHIFT(2), .RELU(1)) u_d1 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iNumRows(iNumRows), .iNumPass(iNumPass),
        .iPsumVld(iPsumVld), .iPsum(iPsum), .oData(oData1), .oValid(oValid1), .iReady(iReady),
        .oBusy(oBusy1), .oDone(oDone1), .oOvf(oOvf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] row(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Sample mid-cycle, then advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(negedge iCLK);
        if (oValid0 && iReady) got0.push_back(oData0);
        if (oValid1 && iReady) got1.push_back(oData1);
        if (oDone0) done_cnt++;
        if (oValid0 && first_vld < 0) first_vld = cyc;
        @(posedge iCLK);
        cyc++;
        #1;
    endtask

    // Column k is presented k cycles after column 0; other lanes carry junk.
    task automatic send_row(input int a, input int b, input int c, input int d, input bit start);
        int v[4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            iPsum = {4{16'h03E8}};
            iPsum[k*16 +: 16] = v[k][15:0];
            iPsumVld = (k == 0);
            iStart = start && (k == 0);
            tick();
        end
        iPsumVld = 1'b0;
        iStart = 1'b0;
    endtask

    task automatic clear();
        got0.delete();
        got1.delete();
        first_vld = -1;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_busy_after"}, 32'(oBusy0), 32'd0);
    endtask

    task automatic run_s1(input string tag);
        clear();
        iReady = 1'b1;
        iNumRows = 5'd2;
        iNumPass = 8'd1;
        mark = cyc;
        send_row(1, 2, 3, 4, 1'b1);
        send_row(5, 6, 7, 8, 1'b0);
        wait_done(tag);
        chk({tag, "_latency"}, 32'(first_vld - mark), 32'd5);
        chk({tag, "_rows"}, 32'(got0.size()), 32'd2);
        chk({tag, "_row0"}, got0[0], row(1, 2, 3, 4));
        chk({tag, "_row1"}, got0[1], row(5, 6, 7, 8));
        chk({tag, "_sh2_row0"}, got1[0], row(0, 1, 1, 1));
        chk({tag, "_sh2_row1"}, got1[1], row(1, 2, 2, 2));
    endtask

    initial begin
        iRSTn = 1'b0; iStart = 1'b0; iNumRows = '0; iNumPass = '0;
        iPsumVld = 1'b0; iPsum = '0; iReady = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(oValid0), 32'd0);
        chk("rst_busy", 32'(oBusy0), 32'd0);
        chk("rst_done", 32'(oDone0), 32'd0);
        chk("rst_ovf", 32'(oOvf0), 32'd0);
        chk("rst_data", oData0, 32'd0);
        chk("rst_d1_flags", {28'd0, oValid1, oBusy1, oDone1, oOvf1}, 32'd0);
        iRSTn = 1'b1;
        repeat (2) tick();

        run_s1("s1");

        // Three passes of 100 per lane: 300 saturates at SHIFT=0, (300+2)>>>2=75 at SHIFT=2.
        clear();
        iNumRows = 5'd1; iNumPass = 8'd3;
        send_row(100, 100, 100, 100, 1'b1);
        send_row(100, 100, 100, 100, 1'b0);
        send_row(100, 100, 100, 100, 1'b0);
        wait_done("s2");
        chk("s2_rows", 32'(got1.size()), 32'd1);
        chk("s2_sh2", got1[0], row(75, 75, 75, 75));
        chk("s2_sh0_sat", got0[0], row(127, 127, 127, 127));

        clear();
        iNumRows = 5'd1; iNumPass = 8'd2;
        send_row(32767, -200, 0, 0, 1'b1);
        send_row(32767, 0, 0, 0, 1'b0);
        wait_done("s3");
        chk("s3_sat_norelu", got0[0], row(127, -128, 0, 0));
        chk("s3_sat_relu", got1[0], row(127, 0, 0, 0));

        // Zero config values behave as one row, one pass.
        clear();
        iNumRows = 5'd0; iNumPass = 8'd0;
        send_row(9, 9, 9, 9, 1'b1);
        wait_done("s7");
        chk("s7_rows", 32'(got0.size()), 32'd1);
        chk("s7_row", got0[0], row(9, 9, 9, 9));

        clear();
        iReady = 1'b0;
        iNumRows = 5'd6; iNumPass = 8'd1;
        for (int r = 0; r < 6; r++)
            send_row(10*r+1, 10*r+2, 10*r+3, 10*r+4, r == 0);
        repeat (4) tick();
        chk("s4_ovf", 32'(oOvf0), 32'd1);
        chk("s4_ovf_d1", 32'(oOvf1), 32'd1);
        chk("s4_valid", 32'(oValid0), 32'd1);
        chk("s4_busy", 32'(oBusy0), 32'd1);
        chk("s4_head", oData0, row(1, 2, 3, 4));
        repeat (3) tick();
        chk("s4_head_stable", oData0, row(1, 2, 3, 4));
        chk("s4_no_pop", 32'(got0.size()), 32'd0);
        iReady = 1'b1;
        wait_done("s4");
        chk("s4_rows", 32'(got0.size()), 32'd4);
        for (int r = 0; r < 4; r++)
            chk($sformatf("s4_row%0d", r), got0[r], row(10*r+1, 10*r+2, 10*r+3, 10*r+4));
        chk("s4_ovf_sticky", 32'(oOvf0), 32'd1);

        // A second iStart mid-RUN with a different row count must be ignored.
        clear();
        iNumRows = 5'd2; iNumPass = 8'd1;
        send_row(1, 1, 1, 1, 1'b1);
        chk("s6_ovf_cleared", 32'(oOvf0), 32'd0);
        iNumRows = 5'd3;
        send_row(2, 2, 2, 2, 1'b1);
        wait_done("s6");
        chk("s6_rows", 32'(got0.size()), 32'd2);
        chk("s6_row1", got0[1], row(2, 2, 2, 2));

        clear();
        iReady = 1'b0;
        iNumRows = 5'd2; iNumPass = 8'd1;
        send_row(1, 2, 3, 4, 1'b1);
        repeat (2) tick();
        chk("s5_pre_valid", 32'(oValid0), 32'd1);
        iRSTn = 1'b0;
        #2;
        chk("s5_rst_valid", 32'(oValid0), 32'd0);
        chk("s5_rst_busy", 32'(oBusy0), 32'd0);
        chk("s5_rst_data", oData0, 32'd0);
        tick();
        iRSTn = 1'b1;
        iReady = 1'b1;
        repeat (6) tick();
        chk("s5_idle_valid", 32'(oValid0), 32'd0);
        run_s1("s5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
